ahb_sram_slave: RTL and testbench

- AHB-Lite slave: on-chip SRAM, 64 x 32-bit words, byte-addressed.
- Sits directly downstream of the bus wrapper interface. It consumes HADDR/HTRANS/HWRITE/HSIZE/HWDATA/HSEL/HREADY and produces HRDATA/HREADYOUT/HRESP.
- Configurable wait states. Two-cycle ERROR response for illegal accesses.
- Memory target for master-side verification.

---
 rtl/ahb_pkg.sv | 23 ++
 rtl/ahb_byte_lane_dec.sv | 30 +++
 rtl/ahb_sram_slave.sv | 137 +++++++++++++
 tb/tb_ahb_sram_slave.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave state type.
package ahb_pkg;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_BUSY   = 2'b01;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    localparam logic [2:0] HS_BYTE = 3'd0;
    localparam logic [2:0] HS_HALF = 3'd1;
    localparam logic [2:0] HS_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_e;

endpackage

// File: rtl/ahb_byte_lane_dec.sv
// Maps a transfer size and the low address bits to little-endian byte enables,
// flagging unsupported sizes and misaligned half/word accesses as illegal.
module ahb_byte_lane_dec
    import ahb_pkg::*;
(
    input  logic [2:0] size_i,
    input  logic [1:0] addr_i,
    output logic [3:0] be_o,
    output logic       illegal_o
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        be_o      = 4'b0000;
        illegal_o = 1'b0;
        case (size_i)
            HS_BYTE: be_o = 4'b0001 << addr_i;
            HS_HALF: begin
                if (addr_i[0]) illegal_o = 1'b1;
                else           be_o      = addr_i[1] ? 4'b1100 : 4'b0011;
            end
            HS_WORD: begin
                if (addr_i != 2'b00) illegal_o = 1'b1;
                else                 be_o      = 4'b1111;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: DEPTH x 32-bit words, byte/half/word access,
// programmable wait states and a two-cycle ERROR response for illegal accesses.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [3:0]        HPROT,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    output logic [DATA_W-1:0] HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP
);

    localparam int DEPTH  = 2 ** (ADDR_W - 2);
    localparam int NBYTES = DATA_W / 8;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [2:0]        size_q, size_d;

    logic              accept;
    logic              phase_done;
    logic              commit;
    logic              illegal_a;
    logic              illegal_dp;
    logic [3:0]        be_a;
    logic [3:0]        be_q;
    logic              unused_bits;

    logic [DATA_W-1:0] mem [DEPTH];

    // Same decoder serves the address-phase legality check and the data-phase lane enables.
    ahb_byte_lane_dec u_dec_addr (
        .size_i    (HSIZE),
        .addr_i    (HADDR[1:0]),
        .be_o      (be_a),
        .illegal_o (illegal_a)
    );

    ahb_byte_lane_dec u_dec_data (
        .size_i    (size_q),
        .addr_i    (addr_q[1:0]),
        .be_o      (be_q),
        .illegal_o (illegal_dp)
    );

    assign unused_bits = ^{HBURST, HPROT, HTRANS[0], be_a, illegal_dp};

    assign accept = HSEL & HREADY & HTRANS[1];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        write_d    = write_q;
        size_d     = size_q;
        HREADYOUT  = 1'b1;
        HRESP      = HRESP_OKAY;
        phase_done = 1'b0;

        case (state_q)
            S_IDLE: phase_done = 1'b1;
            S_DATA: begin
                HREADYOUT = (cnt_q == 3'd0);
                if (cnt_q != 3'd0) cnt_d      = cnt_q - 3'd1;
                else               phase_done = 1'b1;
            end
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_d   = S_ERR2;
            end
            S_ERR2: begin
                HRESP      = HRESP_ERROR;
                phase_done = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // A completed (or absent) data phase lets the next address phase in with no bubble.
        if (phase_done) begin
            state_d = S_IDLE;
            if (accept) begin
                addr_d  = HADDR;
                write_d = HWRITE;
                size_d  = HSIZE;
                state_d = illegal_a ? S_ERR1 : S_DATA;
                cnt_d   = illegal_a ? 3'd0 : 3'(WAIT_STATES);
            end
        end
    end

    always_ff @(posedge HCLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (HRESET) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
        end
    end

    assign commit = (state_q == S_DATA) && (cnt_q == 3'd0) && write_q && !HRESET;

    // NOTE: the memory array has no reset; its contents survive HRESET and it maps to plain RAM.
    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (be_q[i]) mem[addr_q[ADDR_W-1:2]][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    assign HRDATA = ((state_q == S_DATA) && !write_q) ? mem[addr_q[ADDR_W-1:2]] : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: one instance with no wait states, one with three,
// each acting as the only slave on its bus so HREADY follows its own HREADYOUT.
module tb_ahb_sram_slave;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [2:0] SZ_B = 3'd0;
    localparam logic [2:0] SZ_H = 3'd1;
    localparam logic [2:0] SZ_W = 3'd2;
    localparam logic [2:0] SZ_X = 3'd3;

    typedef struct {
        int          dut;
        logic        wr;
        logic [2:0]  sz;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_resp;
        int          exp_low;
    } vec_t;

    logic        hclk;
    logic        hreset    [2];
    logic        hsel      [2];
    logic [7:0]  haddr     [2];
    logic [1:0]  htrans    [2];
    logic        hwrite    [2];
    logic [2:0]  hsize     [2];
    logic [31:0] hwdata    [2];
    logic [31:0] hrdata    [2];
    logic        hreadyout [2];
    logic        hresp     [2];

    int n_cmp  = 0;
    int n_fail = 0;

    ahb_sram_slave #(.ADDR_W(8), .DATA_W(32), .WAIT_STATES(0)) u_ws0 (
        .HCLK(hclk), .HRESET(hreset[0]), .HSEL(hsel[0]), .HADDR(haddr[0]),
        .HTRANS(htrans[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(3'b000),
        .HPROT(4'b0011), .HWDATA(hwdata[0]), .HREADY(hreadyout[0]),
        .HRDATA(hrdata[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0])
    );

    ahb_sram_slave #(.ADDR_W(8), .DATA_W(32), .WAIT_STATES(3)) u_ws3 (
        .HCLK(hclk), .HRESET(hreset[1]), .HSEL(hsel[1]), .HADDR(haddr[1]),
        .HTRANS(htrans[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(3'b000),
        .HPROT(4'b0011), .HWDATA(hwdata[1]), .HREADY(hreadyout[1]),
        .HRDATA(hrdata[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1])
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "global timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle(input int d);
        hsel[d]   = 1'b0;
        htrans[d] = T_IDLE;
        hwrite[d] = 1'b0;
        hsize[d]  = SZ_W;
        haddr[d]  = 8'h00;
    endtask

    task automatic drive_addr(input int d, input logic wr, input logic [2:0] sz, input logic [7:0] a);
        hsel[d]   = 1'b1;
        htrans[d] = T_NONSEQ;
        hwrite[d] = wr;
        hsize[d]  = sz;
        haddr[d]  = a;
    endtask

    // Starts at a data-phase cycle (just after an edge); returns in the completing cycle.
    task automatic wait_done(input int d, output logic [31:0] rd, output logic resp,
                             output int low, output logic low_resp);
        logic done;
        done = 1'b0; low = 0; low_resp = 1'b0; rd = '0; resp = 1'b0;
        for (int g = 0; g < 20 && !done; g++) begin
            @(negedge hclk);
            if (hreadyout[d] === 1'b1) begin
                rd   = hrdata[d];
                resp = hresp[d];
                done = 1'b1;
            end else begin
                low++;
                low_resp = low_resp | hresp[d];
                @(posedge hclk); #1;
            end
        end
        check("data_phase_bound", 32'(done), 32'd1);
    endtask

    task automatic xfer(input vec_t v, output logic [31:0] rd, output logic resp,
                        output int low, output logic low_resp);
        drive_addr(v.dut, v.wr, v.sz, v.addr);
        @(posedge hclk); #1;
        drive_idle(v.dut);
        hwdata[v.dut] = v.wdata;
        wait_done(v.dut, rd, resp, low, low_resp);
        @(posedge hclk); #1;
    endtask

    function automatic vec_t mk(input int d, input logic wr, input logic [2:0] sz, input logic [7:0] a,
                                input logic [31:0] wd, input logic [31:0] er, input logic eresp,
                                input int elow);
        vec_t v;
        v.dut = d; v.wr = wr; v.sz = sz; v.addr = a; v.wdata = wd;
        v.exp_rd = er; v.exp_resp = eresp; v.exp_low = elow;
        return v;
    endfunction

    vec_t        vecs [$];
    logic [31:0] rd;
    logic        resp;
    int          low;
    logic        low_resp;

    initial begin
        // Transfer table: data lanes not being written carry filler that must not land in memory.
        vecs.push_back(mk(0, 1, SZ_W, 8'h10, 32'hDEADBEEF, 32'h0,        0, 0));
        vecs.push_back(mk(0, 0, SZ_W, 8'h10, 32'h0,        32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(0, 1, SZ_B, 8'h20, 32'hAAAAAA11, 32'h0,        0, 0));
        vecs.push_back(mk(0, 1, SZ_B, 8'h21, 32'hBBBB22BB, 32'h0,        0, 0));
        vecs.push_back(mk(0, 1, SZ_B, 8'h22, 32'hCC33CCCC, 32'h0,        0, 0));
        vecs.push_back(mk(0, 1, SZ_B, 8'h23, 32'h44DDDDDD, 32'h0,        0, 0));
        vecs.push_back(mk(0, 0, SZ_W, 8'h20, 32'h0,        32'h44332211, 0, 0));
        vecs.push_back(mk(0, 1, SZ_H, 8'h22, 32'hABCDEEEE, 32'h0,        0, 0));
        vecs.push_back(mk(0, 0, SZ_W, 8'h20, 32'h0,        32'hABCD2211, 0, 0));
        vecs.push_back(mk(0, 1, SZ_H, 8'h20, 32'h99995566, 32'h0,        0, 0));
        vecs.push_back(mk(0, 0, SZ_W, 8'h20, 32'h0,        32'hABCD5566, 0, 0));
        vecs.push_back(mk(0, 0, SZ_B, 8'h21, 32'h0,        32'hABCD5566, 0, 0));
        vecs.push_back(mk(0, 1, SZ_W, 8'h00, 32'hCAFEF00D, 32'h0,        0, 0));
        vecs.push_back(mk(0, 1, SZ_W, 8'h02, 32'hFFFFFFFF, 32'h0,        1, 1));
        vecs.push_back(mk(0, 0, SZ_W, 8'h00, 32'h0,        32'hCAFEF00D, 0, 0));
        vecs.push_back(mk(0, 1, SZ_X, 8'h00, 32'hFFFFFFFF, 32'h0,        1, 1));
        vecs.push_back(mk(0, 0, SZ_W, 8'h00, 32'h0,        32'hCAFEF00D, 0, 0));
        vecs.push_back(mk(0, 1, SZ_H, 8'h01, 32'hFFFFFFFF, 32'h0,        1, 1));
        vecs.push_back(mk(0, 0, SZ_H, 8'h03, 32'h0,        32'h0,        1, 1));
        vecs.push_back(mk(0, 0, SZ_W, 8'h00, 32'h0,        32'hCAFEF00D, 0, 0));
        vecs.push_back(mk(0, 1, SZ_W, 8'hFC, 32'h0BADC0DE, 32'h0,        0, 0));
        vecs.push_back(mk(0, 0, SZ_W, 8'hFC, 32'h0,        32'h0BADC0DE, 0, 0));
        vecs.push_back(mk(1, 1, SZ_W, 8'h40, 32'h01020304, 32'h0,        0, 3));
        vecs.push_back(mk(1, 1, SZ_W, 8'h44, 32'h55667788, 32'h0,        0, 3));
        vecs.push_back(mk(1, 0, SZ_W, 8'h40, 32'h0,        32'h01020304, 0, 3));
        vecs.push_back(mk(1, 1, SZ_W, 8'h43, 32'hFFFFFFFF, 32'h0,        1, 1));
        vecs.push_back(mk(1, 0, SZ_W, 8'h40, 32'h0,        32'h01020304, 0, 3));

        for (int d = 0; d < 2; d++) begin
            hreset[d] = 1'b1;
            hwdata[d] = '0;
            drive_idle(d);
        end
        repeat (3) @(posedge hclk);
        #1;
        hreset[0] = 1'b0;
        hreset[1] = 1'b0;
        @(negedge hclk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_ready_d%0d", d), 32'(hreadyout[d]), 32'd1);
            check($sformatf("reset_resp_d%0d", d),  32'(hresp[d]),     32'd0);
            check($sformatf("reset_rdata_d%0d", d), hrdata[d],         32'h0);
        end
        @(posedge hclk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            xfer(vecs[i], rd, resp, low, low_resp);
            check($sformatf("vec%0d_rdata", i),    rd,            vecs[i].exp_rd);
            check($sformatf("vec%0d_resp", i),     32'(resp),     32'(vecs[i].exp_resp));
            check($sformatf("vec%0d_waits", i),    32'(low),      32'(vecs[i].exp_low));
            check($sformatf("vec%0d_wait_resp", i), 32'(low_resp),
                  (vecs[i].exp_low > 0) ? 32'(vecs[i].exp_resp) : 32'd0);
        end

        // IDLE and BUSY with HSEL high: OKAY, no data phase, no memory update.
        hsel[0] = 1'b1; hwrite[0] = 1'b1; hsize[0] = SZ_W; haddr[0] = 8'h10; hwdata[0] = 32'h0;
        htrans[0] = T_IDLE;
        @(negedge hclk);
        @(posedge hclk); #1;
        @(negedge hclk);
        check("idle_ready", 32'(hreadyout[0]), 32'd1);
        check("idle_resp",  32'(hresp[0]),     32'd0);
        htrans[0] = T_BUSY;
        @(posedge hclk); #1;
        @(negedge hclk);
        check("busy_ready", 32'(hreadyout[0]), 32'd1);
        check("busy_resp",  32'(hresp[0]),     32'd0);
        check("busy_rdata", hrdata[0],         32'h0);
        drive_idle(0);
        @(posedge hclk); #1;
        xfer(mk(0, 0, SZ_W, 8'h10, 32'h0, 32'h0, 0, 0), rd, resp, low, low_resp);
        check("idle_busy_mem_kept", rd, 32'hDEADBEEF);

        // Back-to-back write then read of the same word, no wait states.
        drive_addr(0, 1'b1, SZ_W, 8'h30);
        @(posedge hclk); #1;
        drive_addr(0, 1'b0, SZ_W, 8'h30);
        hwdata[0] = 32'h12345678;
        @(negedge hclk);
        check("b2b_write_ready", 32'(hreadyout[0]), 32'd1);
        @(posedge hclk); #1;
        drive_idle(0);
        @(negedge hclk);
        check("b2b_read_ready", 32'(hreadyout[0]), 32'd1);
        check("b2b_read_resp",  32'(hresp[0]),     32'd0);
        check("b2b_read_rdata", hrdata[0],         32'h12345678);
        @(posedge hclk); #1;

        // Three wait states with the next address held on the bus until HREADY rises.
        drive_addr(1, 1'b0, SZ_W, 8'h40);
        @(posedge hclk); #1;
        drive_addr(1, 1'b0, SZ_W, 8'h44);
        wait_done(1, rd, resp, low, low_resp);
        check("pipe_first_waits", 32'(low), 32'd3);
        check("pipe_first_rdata", rd,       32'h01020304);
        @(posedge hclk); #1;
        drive_idle(1);
        wait_done(1, rd, resp, low, low_resp);
        check("pipe_second_waits", 32'(low), 32'd3);
        check("pipe_second_rdata", rd,       32'h55667788);
        @(posedge hclk); #1;

        // Reset while a write data phase is stalled with two wait cycles remaining.
        drive_addr(1, 1'b1, SZ_W, 8'h40);
        @(posedge hclk); #1;
        drive_idle(1);
        hwdata[1] = 32'hFFFFFFFF;
        @(posedge hclk); #1;
        @(negedge hclk);
        check("rst_mid_stalled", 32'(hreadyout[1]), 32'd0);
        hreset[1] = 1'b1;
        @(posedge hclk); #1;
        hreset[1] = 1'b0;
        @(negedge hclk);
        check("rst_mid_ready", 32'(hreadyout[1]), 32'd1);
        check("rst_mid_resp",  32'(hresp[1]),     32'd0);
        check("rst_mid_rdata", hrdata[1],         32'h0);
        @(posedge hclk); #1;
        xfer(mk(1, 0, SZ_W, 8'h40, 32'h0, 32'h0, 0, 3), rd, resp, low, low_resp);
        check("rst_mid_write_dropped", rd,       32'h01020304);
        check("rst_mid_read_waits",    32'(low), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
